// File: rtl/reorder_out_sched_if.sv
// ---------------------------------------------------------------------------
// reorder_out_sched_if
// Bundle between the reorder output scheduler and its surroundings.
//   done_*      : frame-ready notification from the reorder FSM
//   rd_*        : read port toward the reorder store (data returns 1 cycle
//                 after rd_en_o)
//   out_*       : valid/ready symbol stream toward downstream, SOF/EOF tagged
//   bank_free_* : release pulse for a bank whose last symbol was accepted
//   overflow_o  : a frame-ready notification was dropped
//   busy_o      : scheduler has queued or in-flight work
// Modports: slave = the scheduler, master = the environment driving it.
// ---------------------------------------------------------------------------
interface reorder_out_sched_if #(
  parameter int W = 10
);
  logic         done_i;
  logic         done_bank_i;
  logic         done_use_rec_i;
  logic         rd_en_o;
  logic         rd_sel_o;
  logic         rd_use_rec_o;
  logic [9:0]   rd_addr_o;
  logic [W-1:0] rd_data_i;
  logic         out_vld_o;
  logic         out_rdy_i;
  logic [W-1:0] out_data_o;
  logic         out_sof_o;
  logic         out_eof_o;
  logic         bank_free_o;
  logic         bank_free_sel_o;
  logic         overflow_o;
  logic         busy_o;

  modport slave (
    input  done_i, done_bank_i, done_use_rec_i, rd_data_i, out_rdy_i,
    output rd_en_o, rd_sel_o, rd_use_rec_o, rd_addr_o,
           out_vld_o, out_data_o, out_sof_o, out_eof_o,
           bank_free_o, bank_free_sel_o, overflow_o, busy_o
  );

  modport master (
    output done_i, done_bank_i, done_use_rec_i, rd_data_i, out_rdy_i,
    input  rd_en_o, rd_sel_o, rd_use_rec_o, rd_addr_o,
           out_vld_o, out_data_o, out_sof_o, out_eof_o,
           bank_free_o, bank_free_sel_o, overflow_o, busy_o
  );
endinterface

// File: rtl/reorder_out_sched.sv
// ---------------------------------------------------------------------------
// reorder_out_sched
// Output scheduler of the reorder stage. Frame-ready jobs {bank, use_rec}
// are queued (2 deep), each job is read in address order 0..N-1 from the
// reorder store, and the symbols are streamed downstream through a 2-entry
// skid buffer with SOF/EOF tags. The bank is released one cycle after its
// EOF symbol is accepted.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : reorder_out_sched_if.slave (done/rd/out/bank_free/status)
// N must be at least 2 and at most 1024 (10-bit read address).
// ---------------------------------------------------------------------------
module reorder_out_sched #(
  parameter int W = 10,
  parameter int N = 544
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  reorder_out_sched_if.slave  bus
);

  localparam int             AW        = 10;
  localparam logic [AW-1:0]  ADDR_LAST = AW'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Job queue
  logic [1:0] jq_bank;
  logic [1:0] jq_rec;
  logic       jq_wptr;
  logic       jq_rptr;
  logic [1:0] jq_cnt;
  logic       jq_nempty;
  logic       jq_full;
  logic       jq_push;
  logic       jq_pop;

  // Read sequencer
  logic [0:0]    state_q;
  logic          cur_bank_q;
  logic          cur_rec_q;
  logic [AW-1:0] addr_q;
  logic          job_vld;
  logic          eff_bank;
  logic          eff_rec;
  logic [AW-1:0] eff_addr;
  logic          eff_last;
  logic [2:0]    credit;
  logic          rd_issue;

  // Tags travelling with the read in flight
  logic rd_vld_q;
  logic tag_sof_q;
  logic tag_eof_q;
  logic tag_bank_q;

  // Output buffer
  logic [W-1:0] ob_data [2];
  logic [1:0]   ob_sof;
  logic [1:0]   ob_eof;
  logic [1:0]   ob_bank;
  logic         ob_wptr;
  logic         ob_rptr;
  logic [1:0]   ob_cnt;
  logic         ob_nempty;
  logic         ob_pop;

  logic overflow_q;
  logic bank_free_q;
  logic bank_free_sel_q;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ob_nempty = (ob_cnt != 2'd0);
    ob_pop    = ob_nempty & bus.out_rdy_i;
    jq_nempty = (jq_cnt != 2'd0);
    jq_full   = (jq_cnt == 2'd2);

    // In IDLE the queue head is issued directly so address 0 goes out in the
    // same cycle the job is popped; in READ the latched job drives the port.
    job_vld  = jq_nempty;
    eff_bank = jq_bank[jq_rptr];
    eff_rec  = jq_rec[jq_rptr];
    eff_addr = '0;
    if (state_q == ST_READ) begin
      job_vld  = 1'b1;
      eff_bank = cur_bank_q;
      eff_rec  = cur_rec_q;
      eff_addr = addr_q;
    end
    eff_last = (eff_addr == ADDR_LAST);

    // A symbol leaving the buffer this cycle frees its slot for a read issued
    // now, which keeps one symbol per cycle flowing while never letting
    // buffered plus in-flight entries exceed two.
    credit   = 3'd2 + {2'b00, ob_pop} - {1'b0, ob_cnt} - {2'b00, rd_vld_q};
    rd_issue = job_vld & (credit != 3'd0);

    jq_pop  = jq_nempty & ((state_q == ST_IDLE) | (rd_issue & eff_last));
    jq_push = bus.done_i & (~jq_full | jq_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jq_bank    <= '0;
      jq_rec     <= '0;
      jq_wptr    <= 1'b0;
      jq_rptr    <= 1'b0;
      jq_cnt     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (jq_push) begin
        jq_bank[jq_wptr] <= bus.done_bank_i;
        jq_rec[jq_wptr]  <= bus.done_use_rec_i;
        jq_wptr          <= ~jq_wptr;
      end
      if (jq_pop) jq_rptr <= ~jq_rptr;
      jq_cnt     <= jq_cnt + {1'b0, jq_push} - {1'b0, jq_pop};
      overflow_q <= bus.done_i & jq_full & ~jq_pop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cur_bank_q <= 1'b0;
      cur_rec_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (jq_nempty) begin
            state_q    <= ST_READ;
            cur_bank_q <= jq_bank[jq_rptr];
            cur_rec_q  <= jq_rec[jq_rptr];
            addr_q     <= rd_issue ? AW'(1) : '0;
          end
        end
        default: begin
          if (rd_issue) begin
            if (eff_last) begin
              addr_q <= '0;
              if (jq_nempty) begin
                cur_bank_q <= jq_bank[jq_rptr];
                cur_rec_q  <= jq_rec[jq_rptr];
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q   <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eof_q  <= 1'b0;
      tag_bank_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        tag_sof_q  <= (eff_addr == '0);
        tag_eof_q  <= eff_last;
        tag_bank_q <= eff_bank;
      end
    end
  end

  // NOTE: the two buffer data slots are reset on purpose so out_data_o reads
  // 0 out of reset; a large storage array would be left unreset instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) ob_data[i] <= '0;
      ob_sof  <= '0;
      ob_eof  <= '0;
      ob_bank <= '0;
      ob_wptr <= 1'b0;
      ob_rptr <= 1'b0;
      ob_cnt  <= 2'd0;
    end else begin
      if (rd_vld_q) begin
        ob_data[ob_wptr] <= bus.rd_data_i;
        ob_sof[ob_wptr]  <= tag_sof_q;
        ob_eof[ob_wptr]  <= tag_eof_q;
        ob_bank[ob_wptr] <= tag_bank_q;
        ob_wptr          <= ~ob_wptr;
      end
      if (ob_pop) ob_rptr <= ~ob_rptr;
      ob_cnt <= ob_cnt + {1'b0, rd_vld_q} - {1'b0, ob_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_free_q     <= 1'b0;
      bank_free_sel_q <= 1'b0;
    end else begin
      bank_free_q <= ob_pop & ob_eof[ob_rptr];
      if (ob_pop & ob_eof[ob_rptr]) bank_free_sel_q <= ob_bank[ob_rptr];
    end
  end

  assign bus.rd_en_o         = rd_issue;
  assign bus.rd_sel_o        = eff_bank;
  assign bus.rd_use_rec_o    = eff_rec;
  assign bus.rd_addr_o       = eff_addr;
  assign bus.out_vld_o       = ob_nempty;
  assign bus.out_data_o      = ob_data[ob_rptr];
  assign bus.out_sof_o       = ob_nempty & ob_sof[ob_rptr];
  assign bus.out_eof_o       = ob_nempty & ob_eof[ob_rptr];
  assign bus.bank_free_o     = bank_free_q;
  assign bus.bank_free_sel_o = bank_free_sel_q;
  assign bus.overflow_o      = overflow_q;
  assign bus.busy_o          = jq_nempty | (state_q == ST_READ) | rd_vld_q | ob_nempty;

endmodule

// File: tb/tb_reorder_out_sched.sv
// ---------------------------------------------------------------------------
// tb_reorder_out_sched
// Directed bench for reorder_out_sched. A one-cycle store model returns
// data = address. A negedge monitor records accepted symbols, releases,
// overflow pulses, read-address ordering, output stability under stall and
// the number of reads outstanding; the main sequence compares those records
// against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_reorder_out_sched;

  localparam int W = 10;
  localparam int N = 544;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reorder_out_sched_if #(.W(W)) bus ();

  reorder_out_sched #(.W(W), .N(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Store model: data is the address, returned one cycle after the strobe.
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= W'(bus.rd_addr_o);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eof;
  } sym_t;

  sym_t         out_q[$];
  logic         free_q[$];
  logic         mon_clr = 1'b1;
  int           cyc, n_rd, n_rec, n_raw, first_rd, first_vld, last_done, last_eof;
  int           seq_err, stab_err, free_err, n_ovf, run, max_run, iss, acc, max_out;
  int           prev_addr, exp_addr;
  logic         have_prev, prev_sel, prev_stall, prev_sof, prev_eof;
  logic [W-1:0] prev_data;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; n_rd = 0; n_rec = 0; n_raw = 0; first_rd = -1; first_vld = -1;
      last_done = -100; last_eof = -100; seq_err = 0; stab_err = 0; free_err = 0;
      n_ovf = 0; run = 0; max_run = 0; iss = 0; acc = 0; max_out = 0;
      prev_addr = 0; have_prev = 1'b0; prev_sel = 1'b0; prev_stall = 1'b0;
      prev_sof = 1'b0; prev_eof = 1'b0; prev_data = '0;
      out_q.delete();
      free_q.delete();
    end else begin
      cyc++;
      if (iss - acc > max_out) max_out = iss - acc;
      if (bus.done_i) last_done = cyc;
      if (bus.rd_en_o) begin
        exp_addr = !have_prev ? 0 : ((prev_addr == N - 1) ? 0 : prev_addr + 1);
        if (int'(bus.rd_addr_o) != exp_addr) seq_err++;
        if (have_prev && prev_addr != N - 1 && bus.rd_sel_o !== prev_sel) seq_err++;
        if (n_rd == 0) first_rd = cyc;
        prev_addr = int'(bus.rd_addr_o);
        prev_sel  = bus.rd_sel_o;
        have_prev = 1'b1;
        n_rd++;
        iss++;
        if (bus.rd_use_rec_o) n_rec++; else n_raw++;
      end
      if (prev_stall && !(bus.out_vld_o === 1'b1 && bus.out_data_o === prev_data &&
                          bus.out_sof_o === prev_sof && bus.out_eof_o === prev_eof))
        stab_err++;
      if (bus.out_vld_o) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_vld < 0) first_vld = cyc;
      end else begin
        run = 0;
      end
      prev_stall = bus.out_vld_o & ~bus.out_rdy_i;
      prev_data  = bus.out_data_o;
      prev_sof   = bus.out_sof_o;
      prev_eof   = bus.out_eof_o;
      if (bus.bank_free_o) begin
        free_q.push_back(bus.bank_free_sel_o);
        if (last_eof != cyc - 1) free_err++;
      end
      if (bus.out_vld_o && bus.out_rdy_i) begin
        out_q.push_back({bus.out_data_o, bus.out_sof_o, bus.out_eof_o});
        acc++;
        if (bus.out_eof_o) last_eof = cyc;
      end
      if (bus.overflow_o) n_ovf++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_done(input logic bank, input logic rec);
    bus.done_i         = 1'b1;
    bus.done_bank_i    = bank;
    bus.done_use_rec_i = rec;
    tick();
    bus.done_i = 1'b0;
  endtask

  task automatic wait_syms(input int n, input int budget, input bit rand_rdy, input string tag);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      if (rand_rdy) bus.out_rdy_i = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    bus.out_rdy_i = 1'b1;
    check({tag, "_timeout"}, 64'(k < budget), 64'd1);
    repeat (4) tick();
  endtask

  function automatic int count_bad();
    int bad = 0;
    foreach (out_q[i]) begin
      if (out_q[i].data !== W'(i % N) || out_q[i].sof !== ((i % N) == 0) ||
          out_q[i].eof !== ((i % N) == N - 1))
        bad++;
    end
    return bad;
  endfunction

  function automatic int free_bits();
    int v = 0;
    foreach (free_q[i]) v = (v << 1) | int'(free_q[i]);
    return v;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({bus.rd_en_o, bus.rd_sel_o, bus.rd_use_rec_o, bus.rd_addr_o,
                bus.out_vld_o, bus.out_data_o, bus.out_sof_o, bus.out_eof_o,
                bus.bank_free_o, bus.bank_free_sel_o, bus.overflow_o, bus.busy_o});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bus.done_i         = 1'b0;
    bus.done_bank_i    = 1'b0;
    bus.done_use_rec_i = 1'b0;
    bus.out_rdy_i      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(bus.busy_o), 64'd0);

    // Single frame, bank 1, corrected memory
    clear_mon();
    pulse_done(1'b1, 1'b1);
    wait_syms(N, 800, 1'b0, "single");
    check("single_rd_latency",  64'(first_rd - last_done), 64'd1);
    check("single_vld_latency", 64'(first_vld - last_done), 64'd3);
    check("single_count",       64'(out_q.size()), 64'(N));
    check("single_content",     64'(count_bad()), 64'd0);
    check("single_run",         64'(max_run), 64'(N));
    check("single_free_cnt",    64'(free_q.size()), 64'd1);
    check("single_free_sel",    64'(free_bits()), 64'd1);
    check("single_free_timing", 64'(free_err), 64'd0);
    check("single_rd_seq",      64'(seq_err), 64'd0);
    check("single_rec_reads",   64'(n_rec), 64'(N));
    check("single_busy_after",  64'(bus.busy_o), 64'd0);

    // Random backpressure
    clear_mon();
    pulse_done(1'b1, 1'b1);
    wait_syms(N, 4000, 1'b1, "bp");
    check("bp_count",       64'(out_q.size()), 64'(N));
    check("bp_content",     64'(count_bad()), 64'd0);
    check("bp_stable",      64'(stab_err), 64'd0);
    check("bp_outstanding", 64'(max_out <= 2), 64'd1);
    check("bp_free_sel",    64'(free_bits()), 64'd1);
    check("bp_free_timing", 64'(free_err), 64'd0);
    check("bp_rd_seq",      64'(seq_err), 64'd0);

    // Back-to-back frames, bank 0 then bank 1, five cycles apart
    clear_mon();
    pulse_done(1'b0, 1'b1);
    repeat (4) tick();
    pulse_done(1'b1, 1'b1);
    wait_syms(2 * N, 1400, 1'b0, "b2b");
    check("b2b_count",    64'(out_q.size()), 64'(2 * N));
    check("b2b_content",  64'(count_bad()), 64'd0);
    check("b2b_run",      64'(max_run), 64'(2 * N));
    check("b2b_rd_seq",   64'(seq_err), 64'd0);
    check("b2b_free_cnt", 64'(free_q.size()), 64'd2);
    check("b2b_free_sel", 64'(free_bits()), 64'b01);
    check("b2b_free_tim", 64'(free_err), 64'd0);

    // Overflow: A reading, B and C fill the queue, D is dropped,
    // E arrives in the cycle B is popped and is kept.
    clear_mon();
    pulse_done(1'b0, 1'b1);
    repeat (2) tick();
    pulse_done(1'b1, 1'b1);
    tick();
    pulse_done(1'b0, 1'b1);
    check("ovf_none_when_fits", 64'(bus.overflow_o), 64'd0);
    tick();
    pulse_done(1'b1, 1'b0);
    check("ovf_pulse", 64'(bus.overflow_o), 64'd1);
    tick();
    check("ovf_one_cycle", 64'(bus.overflow_o), 64'd0);
    k = 0;
    while (!(bus.rd_en_o && bus.rd_addr_o == 10'(N - 2)) && k < 700) begin
      tick();
      k++;
    end
    tick();
    check("ovf_pop_cycle", 64'({bus.rd_en_o, bus.rd_addr_o}), 64'({1'b1, 10'(N - 1)}));
    pulse_done(1'b1, 1'b1);
    check("ovf_push_on_pop", 64'(bus.overflow_o), 64'd0);
    wait_syms(4 * N, 2500, 1'b0, "ovf");
    check("ovf_pulses",   64'(n_ovf), 64'd1);
    check("ovf_count",    64'(out_q.size()), 64'(4 * N));
    check("ovf_content",  64'(count_bad()), 64'd0);
    check("ovf_free_cnt", 64'(free_q.size()), 64'd4);
    check("ovf_free_seq", 64'(free_bits()), 64'b0101);

    // Reset at symbol 200, then a raw-memory frame on bank 0
    clear_mon();
    pulse_done(1'b1, 1'b1);
    k = 0;
    while (out_q.size() < 200 && k < 600) begin
      tick();
      k++;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", out_vec(), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_no_free", 64'(free_q.size()), 64'd0);
    check("rst_idle",    64'(bus.busy_o), 64'd0);

    clear_mon();
    pulse_done(1'b0, 1'b0);
    wait_syms(N, 800, 1'b0, "raw");
    check("raw_rd_latency", 64'(first_rd - last_done), 64'd1);
    check("raw_count",      64'(out_q.size()), 64'(N));
    check("raw_content",    64'(count_bad()), 64'd0);
    check("raw_reads",      64'(n_raw), 64'(N));
    check("raw_no_rec",     64'(n_rec), 64'd0);
    check("raw_free_cnt",   64'(free_q.size()), 64'd1);
    check("raw_free_sel",   64'(free_bits()), 64'd0);
    check("raw_rd_seq",     64'(seq_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
